// File: rtl/data_inf_c_intc_m2s_with_lazy_rr.sv
// Round-robin gather arbiter: NUM data_inf_c requesters with lazy sideband onto one
// registered master port. The grant is held per packet or up to MAX_BEAT beats.
module data_inf_c_intc_m2s_with_lazy_rr #(
  parameter int NUM      = 4,
  parameter int NSIZE    = $clog2(NUM),
  parameter int DSIZE    = 32,
  parameter int LAZISE   = 1,
  parameter int MAX_BEAT = 0
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [NUM-1:0][DSIZE-1:0]     s_data,
  input  logic [NUM-1:0][LAZISE-1:0]    s_lazy_data,
  input  logic [NUM-1:0]                s_last,
  input  logic [NUM-1:0]                s_valid,
  output logic [NUM-1:0]                s_ready,
  output logic [DSIZE-1:0]              m_data,
  output logic [LAZISE-1:0]             m_lazy_data,
  output logic                          m_last,
  output logic [NSIZE-1:0]              m_addr,
  output logic                          m_valid,
  input  logic                          m_ready
);

  localparam int CW = 16;
  localparam logic [CW-1:0] LP_LAST_CNT = (MAX_BEAT == 0) ? '0 : CW'(MAX_BEAT - 1);
  localparam logic          LP_LIMITED  = (MAX_BEAT != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            r_state;
  logic [NSIZE-1:0]  r_grant;
  logic [NSIZE-1:0]  r_last_grant;
  logic [CW-1:0]     r_beat_cnt;
  logic [DSIZE-1:0]  r_data;
  logic [LAZISE-1:0] r_lazy;
  logic              r_last;
  logic [NSIZE-1:0]  r_addr;
  logic              r_valid;

  logic              w_found;
  logic [NSIZE-1:0]  w_next;
  logic [NSIZE-1:0]  w_cand;
  logic [NUM-1:0]    w_ready;
  logic              w_accept;
  logic              w_last;

  // Search starts just after the previous owner and wraps.
  always_comb begin
    w_found = 1'b0;
    w_next  = r_last_grant;
    w_cand  = '0;
    for (int i = 1; i <= NUM; i++) begin
      w_cand = NSIZE'((int'(r_last_grant) + i) % NUM);
      if (!w_found && s_valid[w_cand]) begin
        w_found = 1'b1;
        w_next  = w_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == BUSY) w_ready[r_grant] = !r_valid || m_ready;
  end

  assign w_accept = s_valid[r_grant] && w_ready[r_grant];
  assign w_last   = s_last[r_grant] || (LP_LIMITED && (r_beat_cnt == LP_LAST_CNT));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= NSIZE'(NUM - 1);
      r_beat_cnt   <= '0;
      r_data       <= '0;
      r_lazy       <= '0;
      r_last       <= 1'b0;
      r_addr       <= '0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m_ready) r_valid <= 1'b0;
          if (w_found) begin
            r_grant <= w_next;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept) begin
            r_data  <= s_data[r_grant];
            r_lazy  <= s_lazy_data[r_grant];
            r_addr  <= r_grant;
            r_last  <= w_last;
            r_valid <= 1'b1;
            if (w_last) begin
              r_last_grant <= r_grant;
              r_beat_cnt   <= '0;
              r_state      <= IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (m_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready     = w_ready;
  assign m_data      = r_data;
  assign m_lazy_data = r_lazy;
  assign m_last      = r_last;
  assign m_addr      = r_addr;
  assign m_valid     = r_valid;

endmodule

// File: tb/tb_data_inf_c_intc_m2s_with_lazy_rr.sv
// Bench for the round-robin gather arbiter: instance 0 unlimited beats, instance 1 MAX_BEAT=2.
// A packet-level queue model predicts every beat consumed on the master side.
module tb_data_inf_c_intc_m2s_with_lazy_rr;
  localparam int NUM = 4, NSIZE = 2, DSIZE = 32, LAZISE = 1;

  typedef struct packed {
    logic [DSIZE-1:0]  d;
    logic [LAZISE-1:0] lz;
    logic              l;
  } beat_t;

  typedef struct {
    int               k;
    int               addr;
    logic [DSIZE-1:0] d;
    logic             l;
    int               stamp;
  } log_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  logic [NUM-1:0][DSIZE-1:0]  s_data      [2];
  logic [NUM-1:0][LAZISE-1:0] s_lazy_data [2];
  logic [NUM-1:0]             s_last      [2];
  logic [NUM-1:0]             s_valid     [2];
  logic [NUM-1:0]             s_ready     [2];
  logic [DSIZE-1:0]           m_data      [2];
  logic [LAZISE-1:0]          m_lazy_data [2];
  logic                       m_last      [2];
  logic [NSIZE-1:0]           m_addr      [2];
  logic                       m_valid     [2];
  logic                       m_ready     [2];

  data_inf_c_intc_m2s_with_lazy_rr #(.NUM(NUM), .DSIZE(DSIZE), .LAZISE(LAZISE), .MAX_BEAT(0)) u_dut0 (
    .clock(clock), .rst(rst),
    .s_data(s_data[0]), .s_lazy_data(s_lazy_data[0]), .s_last(s_last[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .m_data(m_data[0]), .m_lazy_data(m_lazy_data[0]), .m_last(m_last[0]),
    .m_addr(m_addr[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0])
  );

  data_inf_c_intc_m2s_with_lazy_rr #(.NUM(NUM), .DSIZE(DSIZE), .LAZISE(LAZISE), .MAX_BEAT(2)) u_dut1 (
    .clock(clock), .rst(rst),
    .s_data(s_data[1]), .s_lazy_data(s_lazy_data[1]), .s_last(s_last[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .m_data(m_data[1]), .m_lazy_data(m_lazy_data[1]), .m_last(m_last[1]),
    .m_addr(m_addr[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1])
  );

  beat_t src_q [2][NUM][$];
  beat_t mdl_q [2][NUM][$];
  int    mdl_lg [2];
  int    mdl_gr [2];
  int    mdl_cnt[2];
  bit    acc    [2][NUM];
  logic  pv [2];
  logic  pr [2];
  beat_t pb [2];
  logic [NSIZE-1:0] pa [2];
  int    rdy_mode;
  int    rdy_pat[$];
  log_t  lg_q[$];
  int    cyc;
  int    checks;
  int    errors;

  function automatic int maxb(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  // Packet-level reference: grant goes to the next non-empty requester after the
  // previous owner; a grant ends on the packet's last beat or after maxb beats.
  task automatic model_next(input int k, output bit ok, output int addr, output beat_t b);
    int r;
    ok = 1'b0; addr = 0; b = '0;
    if (mdl_gr[k] < 0) begin
      for (int i = 1; i <= NUM; i++) begin
        r = (mdl_lg[k] + i) % NUM;
        if (mdl_gr[k] < 0 && mdl_q[k][r].size() > 0) mdl_gr[k] = r;
      end
    end
    if (mdl_gr[k] < 0) return;
    ok   = 1'b1;
    addr = mdl_gr[k];
    b    = mdl_q[k][addr].pop_front();
    if (maxb(k) != 0 && mdl_cnt[k] == maxb(k) - 1) b.l = 1'b1;
    mdl_cnt[k]++;
    if (b.l) begin
      mdl_lg[k]  = addr;
      mdl_gr[k]  = -1;
      mdl_cnt[k] = 0;
    end
  endtask

  task automatic clear_all(input int k);
    for (int r = 0; r < NUM; r++) begin
      src_q[k][r].delete();
      mdl_q[k][r].delete();
      acc[k][r] = 1'b0;
    end
    s_valid[k] = '0;
    mdl_lg[k]  = NUM - 1;
    mdl_gr[k]  = -1;
    mdl_cnt[k] = 0;
    pv[k]      = 1'b0;
  endtask

  task automatic push_pkt(input int k, input int r, input int len, input logic [DSIZE-1:0] base,
                          input logic [LAZISE-1:0] lz);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d  = base + DSIZE'(i);
      b.lz = lz;
      b.l  = (i == len - 1);
      src_q[k][r].push_back(b);
      mdl_q[k][r].push_back(b);
    end
  endtask

  // Drivers, monitor and model, all evaluated away from the rising edge.
  initial begin
    bit    ok;
    int    ea;
    beat_t eb;
    log_t  le;
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      clear_all(k);
      s_data[k] = '0; s_lazy_data[k] = '0; s_last[k] = '0; m_ready[k] = 1'b1;
    end
    forever begin
      @(negedge clock);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          clear_all(k);
        end else begin
          for (int r = 0; r < NUM; r++)
            if (acc[k][r] && src_q[k][r].size() > 0) void'(src_q[k][r].pop_front());
          for (int r = 0; r < NUM; r++) begin
            if (src_q[k][r].size() > 0) begin
              s_valid[k][r]     = 1'b1;
              s_data[k][r]      = src_q[k][r][0].d;
              s_lazy_data[k][r] = src_q[k][r][0].lz;
              s_last[k][r]      = src_q[k][r][0].l;
            end else begin
              s_valid[k][r] = 1'b0;
            end
          end
          if (rdy_mode == 1)
            m_ready[k] = ($urandom_range(0, 3) != 0);
          else if (rdy_mode == 2 && k == 0 && m_valid[k] && rdy_pat.size() > 0)
            m_ready[k] = (rdy_pat.pop_front() != 0);
          else
            m_ready[k] = 1'b1;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          for (int r = 0; r < NUM; r++) acc[k][r] = s_valid[k][r] && s_ready[k][r];
          if (pv[k] && !pr[k]) begin
            checks++;
            if (m_valid[k] !== 1'b1 || m_data[k] !== pb[k].d || m_lazy_data[k] !== pb[k].lz ||
                m_last[k] !== pb[k].l || m_addr[k] !== pa[k]) begin
              errors++;
              $display("FAIL stall_hold inst%0d: got v=%b d=%h a=%0d, required v=1 d=%h a=%0d",
                       k, m_valid[k], m_data[k], m_addr[k], pb[k].d, pa[k]);
            end
          end
          if (m_valid[k] && !m_ready[k]) begin
            checks++;
            if (s_ready[k] !== '0) begin
              errors++;
              $display("FAIL s_ready_stall inst%0d: got %b, required 0000", k, s_ready[k]);
            end
          end
          if (m_valid[k] && m_ready[k]) begin
            model_next(k, ok, ea, eb);
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL beat_unexpected inst%0d: got a=%0d d=%h, required no beat", k, m_addr[k], m_data[k]);
            end else if (m_addr[k] !== NSIZE'(ea) || m_data[k] !== eb.d ||
                         m_lazy_data[k] !== eb.lz || m_last[k] !== eb.l) begin
              errors++;
              $display("FAIL beat inst%0d: got a=%0d d=%h lz=%b l=%b, required a=%0d d=%h lz=%b l=%b",
                       k, m_addr[k], m_data[k], m_lazy_data[k], m_last[k], ea, eb.d, eb.lz, eb.l);
            end
            le.k = k; le.addr = int'(m_addr[k]); le.d = m_data[k]; le.l = m_last[k]; le.stamp = cyc;
            lg_q.push_back(le);
          end
          pv[k] = m_valid[k];
          pr[k] = m_ready[k];
          pb[k].d = m_data[k]; pb[k].lz = m_lazy_data[k]; pb[k].l = m_last[k];
          pa[k] = m_addr[k];
        end
      end
    end
  end

  task automatic wait_drain(input int limit);
    bit busy;
    int n;
    n = 0;
    do begin
      @(posedge clock); #2;
      busy = m_valid[0] || m_valid[1];
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < NUM; r++) if (src_q[k][r].size() > 0) busy = 1'b1;
      n++;
    end while (busy && n < limit);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NUM; r++) begin
        checks++;
        if (mdl_q[k][r].size() != 0) begin
          errors++;
          $display("FAIL missing_beats inst%0d req%0d: %0d beats never seen, required 0", k, r, mdl_q[k][r].size());
          mdl_q[k][r].delete();
        end
      end
  endtask

  task automatic wait_log(input int k, input int cnt);
    int n, got;
    n = 0;
    do begin
      @(posedge clock); #2;
      got = 0;
      foreach (lg_q[i]) if (lg_q[i].k == k) got++;
      n++;
    end while (got < cnt && n < 200);
    checks++;
    if (got < cnt) begin
      errors++;
      $display("FAIL log_timeout inst%0d: got %0d beats, required %0d", k, got, cnt);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    rst = 1'b1;
    @(posedge clock); @(posedge clock); #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m_valid[k] !== 1'b0 || m_data[k] !== '0 || m_lazy_data[k] !== '0 ||
          m_last[k] !== 1'b0 || m_addr[k] !== '0 || s_ready[k] !== '0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got v=%b d=%h lz=%b l=%b a=%0d rdy=%b, required all 0",
                 k, m_valid[k], m_data[k], m_lazy_data[k], m_last[k], m_addr[k], s_ready[k]);
      end
    end
    @(posedge clock); #2;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int c;
    rdy_mode = 0; lg_q.delete();
    @(posedge clock); #2;
    c = cyc;
    push_pkt(0, 2, 3, 32'hA0, 1'b1);
    wait_drain(100);
    checks++;
    if (lg_q.size() != 3) begin
      errors++;
      $display("FAIL single_count: got %0d beats, required 3", lg_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (lg_q[i].addr != 2 || lg_q[i].d != 32'hA0 + i || lg_q[i].l != (i == 2) || lg_q[i].stamp != c + 3 + i) begin
          errors++;
          $display("FAIL single_beat%0d: got a=%0d d=%h l=%b t=%0d, required a=2 d=%h l=%b t=%0d",
                   i, lg_q[i].addr, lg_q[i].d, lg_q[i].l, lg_q[i].stamp, 32'hA0 + i, (i == 2), c + 3 + i);
        end
      end
    end
  endtask

  task automatic test_rr_order();
    int c;
    int exp_a[6] = '{0, 0, 1, 1, 3, 3};
    int exp_o[6] = '{3, 4, 6, 7, 9, 10};
    rdy_mode = 0;
    do_reset();
    lg_q.delete();
    @(posedge clock); #2;
    c = cyc;
    push_pkt(0, 0, 2, 32'h100, 1'b0);
    push_pkt(0, 1, 2, 32'h200, 1'b1);
    push_pkt(0, 3, 2, 32'h300, 1'b0);
    wait_drain(100);
    checks++;
    if (lg_q.size() != 6) begin
      errors++;
      $display("FAIL rr_count: got %0d beats, required 6", lg_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (lg_q[i].addr != exp_a[i] || lg_q[i].stamp != c + exp_o[i]) begin
          errors++;
          $display("FAIL rr_beat%0d: got a=%0d t=%0d, required a=%0d t=%0d",
                   i, lg_q[i].addr, lg_q[i].stamp, exp_a[i], c + exp_o[i]);
        end
      end
    end
    lg_q.delete();
    @(posedge clock); #2;
    push_pkt(0, 3, 1, 32'h333, 1'b0);
    push_pkt(0, 0, 1, 32'h111, 1'b0);
    wait_drain(100);
    checks++;
    if (lg_q.size() != 2 || lg_q[0].addr != 0 || lg_q[1].addr != 3) begin
      errors++;
      $display("FAIL rr_last_grant: got %0d beats first a=%0d, required 2 beats order 0,3",
               lg_q.size(), (lg_q.size() > 0) ? lg_q[0].addr : -1);
    end
  endtask

  task automatic test_mid_packet();
    int exp_a[6] = '{0, 0, 0, 0, 1, 1};
    rdy_mode = 0; lg_q.delete();
    @(posedge clock); #2;
    push_pkt(0, 0, 4, 32'h400, 1'b0);
    wait_log(0, 1);
    push_pkt(0, 1, 2, 32'h500, 1'b1);
    wait_drain(100);
    checks++;
    if (lg_q.size() != 6) begin
      errors++;
      $display("FAIL mid_count: got %0d beats, required 6", lg_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (lg_q[i].addr != exp_a[i]) begin
          errors++;
          $display("FAIL mid_order%0d: got a=%0d, required a=%0d", i, lg_q[i].addr, exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    rdy_mode = 2; lg_q.delete();
    rdy_pat = '{1, 0, 0, 1};
    @(posedge clock); #2;
    push_pkt(0, 0, 4, 32'hC0, 1'b1);
    wait_drain(100);
    checks++;
    if (lg_q.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d beats, required 4", lg_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lg_q[i].d != 32'hC0 + i) begin
          errors++;
          $display("FAIL stall_data%0d: got %h, required %h", i, lg_q[i].d, 32'hC0 + i);
        end
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_max_beat();
    int   exp_a[7] = '{0, 0, 1, 1, 0, 0, 0};
    logic exp_l[7] = '{0, 1, 0, 1, 0, 1, 1};
    int   j;
    rdy_mode = 0; lg_q.delete();
    @(posedge clock); #2;
    push_pkt(1, 0, 5, 32'hB0, 1'b0);
    push_pkt(1, 1, 2, 32'hD0, 1'b1);
    wait_drain(100);
    j = 0;
    foreach (lg_q[i]) begin
      if (lg_q[i].k == 1) begin
        checks++;
        if (j >= 7 || lg_q[i].addr != exp_a[j] || lg_q[i].l != exp_l[j]) begin
          errors++;
          $display("FAIL maxbeat_beat%0d: got a=%0d l=%b, required a=%0d l=%b",
                   j, lg_q[i].addr, lg_q[i].l, (j < 7) ? exp_a[j] : -1, (j < 7) ? exp_l[j] : 1'b0);
        end
        j++;
      end
    end
    checks++;
    if (j != 7) begin
      errors++;
      $display("FAIL maxbeat_count: got %0d beats, required 7", j);
    end
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0; lg_q.delete();
    @(posedge clock); #2;
    push_pkt(0, 0, 4, 32'hE0, 1'b0);
    wait_log(0, 1);
    checks++;
    if (m_valid[0] !== 1'b1 || m_data[0] !== 32'hE1) begin
      errors++;
      $display("FAIL rstmid_pre: got v=%b d=%h, required v=1 d=000000e1", m_valid[0], m_data[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid[0] !== 1'b0 || s_ready[0] !== '0 || m_addr[0] !== '0) begin
      errors++;
      $display("FAIL rstmid_during: got v=%b rdy=%b a=%0d, required 0", m_valid[0], s_ready[0], m_addr[0]);
    end
    @(posedge clock); @(posedge clock); #2;
    rst = 1'b0;
    lg_q.delete();
    @(posedge clock); #2;
    push_pkt(0, 2, 1, 32'hF0, 1'b0);
    push_pkt(0, 1, 1, 32'hF8, 1'b1);
    wait_drain(100);
    checks++;
    if (lg_q.size() != 2 || lg_q[0].addr != 1 || lg_q[1].addr != 2) begin
      errors++;
      $display("FAIL rstmid_after: got %0d beats first a=%0d, required order 1,2",
               lg_q.size(), (lg_q.size() > 0) ? lg_q[0].addr : -1);
    end
  endtask

  task automatic test_random();
    int n, len;
    for (int it = 0; it < 20; it++) begin
      rdy_mode = 1;
      @(posedge clock); #2;
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < NUM; r++) begin
          n = $urandom_range(0, 2);
          for (int p = 0; p < n; p++) begin
            len = $urandom_range(1, 5);
            push_pkt(k, r, len, $urandom, LAZISE'($urandom));
          end
        end
      wait_drain(2000);
    end
    rdy_mode = 0;
  endtask

  initial begin
    checks = 0; errors = 0; rdy_mode = 0;
    test_reset();
    test_single();
    test_rr_order();
    test_mid_packet();
    test_stall();
    test_max_beat();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
